// File: rtl/chip8_pkg.sv
// Shared constants, the built-in hex font and the loader state encoding for the CHIP-8 program loader.
package chip8_pkg;

    localparam logic [11:0] FONT_BASE    = 12'h050;
    localparam logic [11:0] PROG_BASE    = 12'h200;
    localparam logic [11:0] MAX_PROG_LEN = 12'hE00;
    localparam int          FONT_BYTES   = 80;

    // Standard 4x5 sprites for hex digits 0..F, five rows each.
    localparam logic [7:0] FONT [FONT_BYTES] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    typedef enum logic [2:0] {
        ST_IDLE, ST_FONT, ST_HDR, ST_PROG, ST_DRAIN, ST_CLEAR, ST_DONE
    } loader_state_t;

    // Program length from the big-endian header, limited to the space above PROG_BASE.
    function automatic logic [11:0] clamp_len(input logic [15:0] raw);
        return (raw > {4'h0, MAX_PROG_LEN}) ? MAX_PROG_LEN : raw[11:0];
    endfunction

endpackage

// File: rtl/chip8_lib_read_pipe.sv
// Delay line of {valid, destination address} that lines each library read up with the ROM data
// arriving LAT cycles after its address.
module chip8_lib_read_pipe
    import chip8_pkg::*;
#(
    parameter int LAT = 2,
    parameter int AW  = $bits(PROG_BASE)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          valid_in,
    input  logic [AW-1:0] addr_in,
    output logic          valid_out,
    output logic [AW-1:0] addr_out,
    output logic          busy_out
);

    logic [LAT-1:0] valid_q, valid_d;
    logic [AW-1:0]  addr_q [LAT];
    logic [AW-1:0]  addr_d [LAT];

    // Shift every stage forward by one.
    always_comb begin
        valid_d    = valid_q;
        valid_d[0] = valid_in;
        addr_d     = addr_q;
        addr_d[0]  = addr_in;
        for (int i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            addr_d[i]  = addr_q[i-1];
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_out = valid_q[LAT-1];
    assign addr_out  = addr_q[LAT-1];
    assign busy_out  = |valid_q;

endmodule

// File: rtl/chip8_program_loader.sv
// Fills CHIP-8 memory on request: hex font, then one library program at PROG_BASE, then zeroes
// the remainder up to 0xFFF. All outputs are registered.
module chip8_program_loader
    import chip8_pkg::*;
#(
    parameter  int NUM_PROGRAMS = 16,
    parameter  int SLOT_BYTES   = 4096,
    parameter  int LIB_LATENCY  = 2,
    localparam int SEL_W        = $clog2(NUM_PROGRAMS),
    localparam int LAW          = $clog2(NUM_PROGRAMS * SLOT_BYTES)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             flash_in,
    input  logic [SEL_W-1:0] program_sel_in,
    output logic [LAW-1:0]   lib_addr_out,
    input  logic [7:0]       lib_data_in,
    output logic [11:0]      mem_addr_out,
    output logic [7:0]       mem_data_out,
    output logic             mem_we_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             len_err_out
);

    loader_state_t    state_q, state_d;
    logic [11:0]      cnt_q, cnt_d;
    logic [11:0]      len_q, len_d;
    logic [7:0]       hdr_hi_q, hdr_hi_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             issue_valid_q, issue_valid_d;
    logic [11:0]      issue_dst_q, issue_dst_d;
    logic [LAW-1:0]   lib_addr_q, lib_addr_d;
    logic [11:0]      mem_addr_q, mem_addr_d;
    logic [7:0]       mem_data_q, mem_data_d;
    logic             mem_we_q, mem_we_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             len_err_q, len_err_d;

    logic             pipe_valid_s;
    logic [11:0]      pipe_addr_s;
    logic             pipe_busy_s;
    logic [LAW-1:0]   slot_base_s;
    logic [15:0]      hdr_raw_s;

    assign slot_base_s = LAW'(sel_q) * LAW'(SLOT_BYTES);
    assign hdr_raw_s   = {hdr_hi_q, lib_data_in};

    // issue_* registers sit alongside lib_addr_q, so LIB_LATENCY further stages meet the data.
    chip8_lib_read_pipe #(.LAT(LIB_LATENCY), .AW(12)) u_pipe (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .valid_in  (issue_valid_q),
        .addr_in   (issue_dst_q),
        .valid_out (pipe_valid_s),
        .addr_out  (pipe_addr_s),
        .busy_out  (pipe_busy_s)
    );

    // Next-state and next-output logic for the whole load sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        hdr_hi_d      = hdr_hi_q;
        sel_d         = sel_q;
        issue_valid_d = 1'b0;
        issue_dst_d   = issue_dst_q;
        lib_addr_d    = lib_addr_q;
        mem_we_d      = pipe_valid_s;
        busy_d        = busy_q;
        done_d        = 1'b0;
        len_err_d     = len_err_q;
        if (pipe_valid_s) begin
            mem_addr_d = pipe_addr_s;
            mem_data_d = lib_data_in;
        end else begin
            mem_addr_d = mem_addr_q;
            mem_data_d = mem_data_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (flash_in) begin
                    state_d   = ST_FONT;
                    sel_d     = program_sel_in;
                    len_err_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = 12'd0;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_FONT: begin
                mem_we_d   = 1'b1;
                mem_addr_d = FONT_BASE + cnt_q;
                mem_data_d = FONT[cnt_q[6:0]];
                if (cnt_q == 12'(FONT_BYTES - 1)) begin
                    state_d    = ST_HDR;
                    cnt_d      = 12'd0;
                    lib_addr_d = slot_base_s;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            ST_HDR: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == 12'd0) begin
                    lib_addr_d = slot_base_s + LAW'(1);
                end else begin
                    lib_addr_d = lib_addr_q;
                end
                if (cnt_q == 12'(LIB_LATENCY)) begin
                    hdr_hi_d = lib_data_in;
                end else begin
                    hdr_hi_d = hdr_hi_q;
                end
                // Low header byte is on lib_data_in now; the first program read goes out on this edge.
                if (cnt_q == 12'(LIB_LATENCY + 1)) begin
                    len_d     = clamp_len(hdr_raw_s);
                    len_err_d = (hdr_raw_s > {4'h0, MAX_PROG_LEN});
                    if (clamp_len(hdr_raw_s) == 12'd0) begin
                        state_d = ST_CLEAR;
                        cnt_d   = PROG_BASE;
                    end else begin
                        state_d       = ST_PROG;
                        cnt_d         = 12'd0;
                        issue_valid_d = 1'b1;
                        issue_dst_d   = PROG_BASE;
                        lib_addr_d    = slot_base_s + LAW'(2);
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PROG: begin
                if (cnt_q + 12'd1 < len_q) begin
                    cnt_d         = cnt_q + 12'd1;
                    issue_valid_d = 1'b1;
                    issue_dst_d   = PROG_BASE + cnt_q + 12'd1;
                    lib_addr_d    = slot_base_s + LAW'(cnt_q) + LAW'(3);
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!issue_valid_q && !pipe_busy_s) begin
                    if (len_q == MAX_PROG_LEN) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CLEAR;
                        cnt_d   = PROG_BASE + len_q;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                mem_we_d   = 1'b1;
                mem_addr_d = cnt_q;
                mem_data_d = 8'h00;
                if (cnt_q == 12'hFFF) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 12'd0;
            len_q         <= 12'd0;
            hdr_hi_q      <= 8'h00;
            sel_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_dst_q   <= 12'd0;
            lib_addr_q    <= '0;
            mem_addr_q    <= 12'd0;
            mem_data_q    <= 8'h00;
            mem_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            hdr_hi_q      <= hdr_hi_d;
            sel_q         <= sel_d;
            issue_valid_q <= issue_valid_d;
            issue_dst_q   <= issue_dst_d;
            lib_addr_q    <= lib_addr_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            mem_we_q      <= mem_we_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            len_err_q     <= len_err_d;
        end
    end

    assign lib_addr_out = lib_addr_q;
    assign mem_addr_out = mem_addr_q;
    assign mem_data_out = mem_data_q;
    assign mem_we_out   = mem_we_q;
    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign len_err_out  = len_err_q;

endmodule

// File: tb/tb_chip8_program_loader.sv
// Runs three loaders (library latency 2, 1 and 4) side by side on shared stimulus, each with its
// own ROM delay line and shadow memory, and compares the memory image against a reference.
module tb_chip8_program_loader;

    localparam int NI         = 3;
    localparam int LATS [NI]  = '{2, 1, 4};
    localparam int TOTAL_WR   = 80 + 'hE00;
    localparam int RUN_BOUND  = 6000;

    localparam logic [7:0] FONT_REF [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    logic clk = 1'b0;
    logic rst_n;
    logic flash;
    logic [3:0] sel;

    logic [NI-1:0][15:0] lib_addr;
    logic [NI-1:0][7:0]  lib_data;
    logic [NI-1:0][11:0] mem_addr;
    logic [NI-1:0][7:0]  mem_data;
    logic [NI-1:0]       mem_we;
    logic [NI-1:0]       busy;
    logic [NI-1:0]       done;
    logic [NI-1:0]       len_err;

    logic [7:0] rom   [65536];
    logic [7:0] rpipe [NI][4];
    logic [7:0] shadow [NI][4096];
    logic [7:0] expm  [4096];
    int wr_cnt [NI];
    int ord_err [NI];
    int done_cnt [NI];
    int last_cyc [NI];
    int cyc;
    logic clr;
    int exp_len;
    logic exp_err;
    logic prev_err;
    int tests;
    int fails;

    always #5 clk = ~clk;

    chip8_program_loader #(.LIB_LATENCY(2)) u_dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .flash_in(flash), .program_sel_in(sel),
        .lib_addr_out(lib_addr[0]), .lib_data_in(lib_data[0]), .mem_addr_out(mem_addr[0]),
        .mem_data_out(mem_data[0]), .mem_we_out(mem_we[0]), .busy_out(busy[0]),
        .done_out(done[0]), .len_err_out(len_err[0]));
    chip8_program_loader #(.LIB_LATENCY(1)) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .flash_in(flash), .program_sel_in(sel),
        .lib_addr_out(lib_addr[1]), .lib_data_in(lib_data[1]), .mem_addr_out(mem_addr[1]),
        .mem_data_out(mem_data[1]), .mem_we_out(mem_we[1]), .busy_out(busy[1]),
        .done_out(done[1]), .len_err_out(len_err[1]));
    chip8_program_loader #(.LIB_LATENCY(4)) u_dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .flash_in(flash), .program_sel_in(sel),
        .lib_addr_out(lib_addr[2]), .lib_data_in(lib_data[2]), .mem_addr_out(mem_addr[2]),
        .mem_data_out(mem_data[2]), .mem_we_out(mem_we[2]), .busy_out(busy[2]),
        .done_out(done[2]), .len_err_out(len_err[2]));

    // Library ROM: data appears LATS[i] cycles after its address.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            rpipe[i][0] <= rom[lib_addr[i]];
            for (int j = 1; j < 4; j++) rpipe[i][j] <= rpipe[i][j-1];
        end
    end

    always_comb begin
        lib_data = '0;
        for (int i = 0; i < NI; i++) lib_data[i] = rpipe[i][LATS[i]-1];
    end

    // Expected position of the n-th write of a run: font in order, then program bytes back to back.
    function automatic int order_bad(input int n, input logic [11:0] a, input int c,
                                     input int lc, input int len);
        if (n < 80) return (a != 12'(12'h050 + n)) ? 1 : 0;
        if (n < 80 + len) return ((a != 12'(12'h200 + n - 80)) || (n > 80 && c != lc + 1)) ? 1 : 0;
        return 0;
    endfunction

    // Shadow memories and per-run write statistics.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (clr) begin
                wr_cnt[i]   <= 0;
                ord_err[i]  <= 0;
                done_cnt[i] <= 0;
                last_cyc[i] <= 0;
                for (int a = 0; a < 4096; a++) shadow[i][a] <= 8'hAA;
            end else begin
                if (mem_we[i] === 1'b1) begin
                    shadow[i][mem_addr[i]] <= mem_data[i];
                    wr_cnt[i]   <= wr_cnt[i] + 1;
                    last_cyc[i] <= cyc;
                end
                ord_err[i] <= ord_err[i]
                    + ((mem_we[i] === 1'b1) ? order_bad(wr_cnt[i], mem_addr[i], cyc, last_cyc[i], exp_len) : 0)
                    + ((mem_we[i] === 1'b1 && busy[i] !== 1'b1) ? 1 : 0)
                    + ((done[i] === 1'b1 && busy[i] !== 1'b0) ? 1 : 0);
                if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitor;
        clr = 1'b1;
        @(negedge clk);
        #1;
        clr = 1'b0;
    endtask

    // Reference image: untouched bytes stay 0xAA, font, program bytes, zero fill to 0xFFF.
    task automatic build_expect(input int s);
        int base;
        int raw;
        base    = s * 4096;
        raw     = {rom[base], rom[base + 1]};
        exp_err = (raw > 'hE00);
        exp_len = exp_err ? 'hE00 : raw;
        for (int a = 0; a < 4096; a++) expm[a] = 8'hAA;
        for (int k = 0; k < 80; k++) expm['h050 + k] = FONT_REF[k];
        for (int k = 0; k < 'hE00; k++) expm['h200 + k] = (k < exp_len) ? rom[base + 2 + k] : 8'h00;
    endtask

    task automatic start(input int s, input string tag);
        build_expect(s);
        for (int i = 0; i < NI; i++) chk(32'(len_err[i]), 32'(prev_err), $sformatf("%s/L%0d/err_held", tag, LATS[i]));
        clear_monitor();
        sel   = 4'(s);
        flash = 1'b1;
        tick();
        flash = 1'b0;
        sel   = 4'(s + 1);
        for (int i = 0; i < NI; i++) begin
            chk(32'(busy[i]), 32'd1, $sformatf("%s/L%0d/busy_start", tag, LATS[i]));
            chk(32'(len_err[i]), 32'd0, $sformatf("%s/L%0d/err_clear", tag, LATS[i]));
        end
    endtask

    task automatic run(input int s, input int mid_sel, input string tag);
        int n;
        int mism;
        start(s, tag);
        if (mid_sel >= 0) begin
            repeat (100) tick();
            sel   = 4'(mid_sel);
            flash = 1'b1;
            tick();
            flash = 1'b0;
        end
        n = 0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0) && n < RUN_BOUND) begin
            tick();
            n++;
        end
        chk(32'(n < RUN_BOUND), 32'd1, {tag, "/finished_in_bound"});
        repeat (5) tick();
        for (int i = 0; i < NI; i++) begin
            mism = 0;
            for (int a = 0; a < 4096; a++) if (shadow[i][a] !== expm[a]) mism++;
            chk(32'(mism), 32'd0, $sformatf("%s/L%0d/bad_bytes", tag, LATS[i]));
            chk(32'(wr_cnt[i]), 32'(TOTAL_WR), $sformatf("%s/L%0d/writes", tag, LATS[i]));
            chk(32'(ord_err[i]), 32'd0, $sformatf("%s/L%0d/order_errs", tag, LATS[i]));
            chk(32'(done_cnt[i]), 32'd1, $sformatf("%s/L%0d/done_pulses", tag, LATS[i]));
            chk(32'(len_err[i]), 32'(exp_err), $sformatf("%s/L%0d/len_err", tag, LATS[i]));
            chk(32'(busy[i]), 32'd0, $sformatf("%s/L%0d/busy_end", tag, LATS[i]));
        end
        prev_err = exp_err;
    endtask

    task automatic set_len(input int s, input int len);
        rom[s * 4096]     = 8'(len >> 8);
        rom[s * 4096 + 1] = 8'(len);
    endtask

    initial begin
        int len9;
        int len11;
        tests = 0;
        fails = 0;
        clr   = 1'b0;
        rst_n = 1'b0;
        flash = 1'b0;
        sel   = 4'd0;
        prev_err = 1'b0;
        exp_len  = 0;

        for (int a = 0; a < 65536; a++) rom[a] = 8'($urandom);
        set_len(0, 'h10);
        set_len(3, 4);
        rom[3 * 4096 + 2] = 8'h12; rom[3 * 4096 + 3] = 8'h34;
        rom[3 * 4096 + 4] = 8'h56; rom[3 * 4096 + 5] = 8'h78;
        set_len(5, 0);
        set_len(7, 'hFFFF);
        for (int k = 0; k < 4094; k++) rom[7 * 4096 + 2 + k] = 8'(k * 7 + 1);
        len9 = int'($urandom_range(1, 'hE00));
        set_len(9, len9);
        for (int k = 0; k < 4094; k++) rom[9 * 4096 + 2 + k] = 8'(k ^ (k >> 8));
        len11 = int'($urandom_range(300, 600));
        set_len(11, len11);
        set_len(12, 'hE00);
        set_len(13, 'hE01);
        set_len(14, 1);

        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            chk(32'({busy[i], done[i], len_err[i], mem_we[i]}), 32'd0, $sformatf("reset/L%0d/flags", LATS[i]));
            chk(32'(lib_addr[i]), 32'd0, $sformatf("reset/L%0d/lib_addr", LATS[i]));
            chk(32'({mem_addr[i], mem_data[i]}), 32'd0, $sformatf("reset/L%0d/mem_bus", LATS[i]));
        end
        rst_n = 1'b1;
        tick();

        run(0, -1, "font");
        chk(32'(shadow[0]['h050]), 32'hF0, "font/0x050");
        chk(32'(shadow[0]['h051]), 32'h90, "font/0x051");
        chk(32'(shadow[0]['h09F]), 32'h80, "font/0x09F");
        run(3, -1, "prog4");
        chk(32'({shadow[0]['h200], shadow[0]['h201], shadow[0]['h202], shadow[0]['h203]}), 32'h12345678, "prog4/bytes");
        chk(32'(shadow[0]['h204]), 32'h00, "prog4/0x204");
        run(5, -1, "empty");
        run(7, -1, "oversize");
        run(12, -1, "exact_max");
        run(13, -1, "max_plus1");
        run(9, -1, "sweep");
        run(14, -1, "len1");
        run(11, 2, "mid_flash");

        start(11, "rst_mid");
        repeat (120) tick();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk(32'({busy[i], done[i], len_err[i], mem_we[i]}), 32'd0, $sformatf("rst_mid/L%0d/flags", LATS[i]));
            chk(32'(lib_addr[i]), 32'd0, $sformatf("rst_mid/L%0d/lib_addr", LATS[i]));
            chk(32'({mem_addr[i], mem_data[i]}), 32'd0, $sformatf("rst_mid/L%0d/mem_bus", LATS[i]));
        end
        repeat (2) tick();
        rst_n = 1'b1;
        prev_err = 1'b0;
        tick();
        run(11, -1, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
